// File: rtl/pit_timer.sv
// pit_timer: 8254-style programmable interval timer, channel 0 only (modes 0/2/3),
// programmed via byte-wide port writes; irq0_o pulses on each rising edge of out0_o.
module pit_timer #(
    parameter int unsigned PRESCALE  = 4,
    parameter logic [7:0]  CTRL_PORT = 8'h43,
    parameter logic [7:0]  CNT0_PORT = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic       re_i,
    input  logic [7:0] port_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       out0_o,
    output logic       irq0_o
);
    typedef enum logic [1:0] {MODE0 = 2'd0, MODE2 = 2'd2, MODE3 = 2'd3} mode_t;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2} chan_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    function automatic mode_t f_mode(input logic [1:0] m);
        case (m)
            2'b10:   f_mode = MODE2;
            2'b11:   f_mode = MODE3;
            default: f_mode = MODE0;
        endcase
    endfunction

    // Mode 3 runs each half-period as its own down-count; count 0 means 65536.
    function automatic logic [15:0] f_hi(input logic [15:0] n);
        f_hi = (n == 16'h0000) ? 16'h8000 : ((n >> 1) + {15'h0000, n[0]});
    endfunction

    function automatic logic [15:0] f_lo(input logic [15:0] n);
        f_lo = (n == 16'h0000) ? 16'h8000 : (n >> 1);
    endfunction

    logic [PW-1:0] r_presc;
    mode_t         r_mode;
    chan_t         r_state;
    logic [1:0]    r_rw;
    logic          r_wr_ff;
    logic          r_rd_ff;
    logic [7:0]    r_lsb;
    logic [15:0]   r_cr;
    logic [15:0]   r_counter;
    logic [15:0]   r_latch;
    logic          r_latch_vld;
    logic [7:0]    r_data;
    logic          r_out;
    logic          r_irq;

    logic          w_tick;
    logic          w_ctrl_wr;
    logic          w_latch_cmd;
    logic          w_cnt_wr;
    logic          w_cnt_done;
    logic [15:0]   w_cnt_val;
    logic [15:0]   w_cnt_adj;
    logic [15:0]   w_rd_src;
    logic [7:0]    w_rd_byte;
    logic          w_rd_last;

    assign w_tick      = (r_presc == PW'(PRESCALE - 1));
    assign w_ctrl_wr   = we_i && (port_i == CTRL_PORT) && (data_i[7:6] == 2'b00);
    assign w_latch_cmd = w_ctrl_wr && (data_i[5:4] == 2'b00);
    assign w_cnt_wr    = we_i && (port_i == CNT0_PORT);

    assign data_o = r_data;
    assign out0_o = r_out;
    assign irq0_o = r_irq;

    // Count-word assembly from the data port according to the RW field.
    always_comb begin
        w_cnt_done = 1'b0;
        w_cnt_val  = 16'h0000;
        if (w_cnt_wr) begin
            case (r_rw)
                2'b01: begin
                    w_cnt_done = 1'b1;
                    w_cnt_val  = {8'h00, data_i};
                end
                2'b10: begin
                    w_cnt_done = 1'b1;
                    w_cnt_val  = {data_i, 8'h00};
                end
                2'b11: begin
                    w_cnt_done = r_wr_ff;
                    w_cnt_val  = {data_i, r_lsb};
                end
                default: begin
                    w_cnt_done = 1'b0;
                end
            endcase
        end else begin
            w_cnt_done = 1'b0;
        end
        if ((w_cnt_val == 16'h0001) && (r_mode != MODE0)) begin
            w_cnt_adj = 16'h0002;
        end else begin
            w_cnt_adj = w_cnt_val;
        end
    end

    // Read-back byte selection: latched value takes precedence over the live counter.
    always_comb begin
        w_rd_src = r_latch_vld ? r_latch : r_counter;
        case (r_rw)
            2'b10:   w_rd_byte = w_rd_src[15:8];
            2'b11:   w_rd_byte = r_rd_ff ? w_rd_src[15:8] : w_rd_src[7:0];
            default: w_rd_byte = w_rd_src[7:0];
        endcase
        w_rd_last = (r_rw != 2'b11) || r_rd_ff;
    end

    // Free-running prescaler producing the counter tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Channel state, counting, port access; later statements take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= MODE0;
            r_state     <= ST_IDLE;
            r_rw        <= 2'b11;
            r_wr_ff     <= 1'b0;
            r_rd_ff     <= 1'b0;
            r_lsb       <= 8'h00;
            r_cr        <= 16'h0000;
            r_counter   <= 16'h0000;
            r_latch     <= 16'h0000;
            r_latch_vld <= 1'b0;
            r_data      <= 8'h00;
            r_out       <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= 1'b0;

            if (re_i) begin
                if (port_i == CNT0_PORT) begin
                    r_data <= w_rd_byte;
                    if (r_rw == 2'b11) begin
                        r_rd_ff <= ~r_rd_ff;
                    end
                    if (w_rd_last) begin
                        r_latch_vld <= 1'b0;
                    end
                end else begin
                    r_data <= 8'h00;
                end
            end

            if (w_tick) begin
                case (r_state)
                    ST_LOAD: begin
                        r_state <= ST_RUN;
                        if (r_mode == MODE3) begin
                            r_counter <= f_hi(r_cr);
                            r_out     <= 1'b1;
                        end else if (r_mode == MODE2) begin
                            r_counter <= r_cr;
                            r_out     <= 1'b1;
                        end else begin
                            r_counter <= r_cr;
                        end
                    end
                    ST_RUN: begin
                        case (r_mode)
                            MODE2: begin
                                if (r_counter == 16'h0001) begin
                                    r_counter <= r_cr;
                                    r_out     <= 1'b1;
                                    r_irq     <= ~r_out;
                                end else begin
                                    r_counter <= r_counter - 16'd1;
                                    if (r_counter == 16'h0002) begin
                                        r_out <= 1'b0;
                                    end
                                end
                            end
                            MODE3: begin
                                if (r_counter == 16'h0001) begin
                                    r_counter <= r_out ? f_lo(r_cr) : f_hi(r_cr);
                                    r_out     <= ~r_out;
                                    r_irq     <= ~r_out;
                                end else begin
                                    r_counter <= r_counter - 16'd1;
                                end
                            end
                            default: begin
                                r_counter <= r_counter - 16'd1;
                                if (r_counter == 16'h0001) begin
                                    r_out <= 1'b1;
                                    r_irq <= ~r_out;
                                end
                            end
                        endcase
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end

            if (w_cnt_wr && (r_rw == 2'b11)) begin
                r_wr_ff <= ~r_wr_ff;
                if (!r_wr_ff) begin
                    r_lsb <= data_i;
                end
            end

            // A running mode 2/3 channel only picks up the new count at its next reload.
            if (w_cnt_done) begin
                r_cr <= w_cnt_adj;
                if (r_mode == MODE0) begin
                    r_state <= ST_LOAD;
                    r_out   <= 1'b0;
                    r_irq   <= 1'b0;
                end else if (r_state != ST_RUN) begin
                    r_state <= ST_LOAD;
                end
            end

            if (w_latch_cmd && !r_latch_vld) begin
                r_latch     <= r_counter;
                r_latch_vld <= 1'b1;
            end

            if (w_ctrl_wr && !w_latch_cmd) begin
                r_mode  <= f_mode(data_i[2:1]);
                r_rw    <= data_i[5:4];
                r_wr_ff <= 1'b0;
                r_rd_ff <= 1'b0;
                r_state <= ST_IDLE;
                r_out   <= (f_mode(data_i[2:1]) != MODE0);
                r_irq   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pit_timer.sv
// tb_pit_timer: directed scoreboard bench for pit_timer (PRESCALE=1); stimulus pushes
// expected read bytes, irq0_o edge numbers and out0_o levels, a monitor pops and compares.
module tb_pit_timer;
    localparam logic [7:0] CTRL = 8'h43;
    localparam logic [7:0] CNT0 = 8'h40;

    logic       clk;
    logic       rst;
    logic       we_i;
    logic       re_i;
    logic [7:0] port_i;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       out0_o;
    logic       irq0_o;

    typedef struct {
        int   cyc;
        logic lvl;
    } lvl_t;

    logic [7:0] q_rd[$];
    int         q_irq[$];
    lvl_t       q_lvl[$];

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    pit_timer #(
        .PRESCALE  (1),
        .CTRL_PORT (8'h43),
        .CNT0_PORT (8'h40)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_i),
        .re_i   (re_i),
        .port_i (port_i),
        .data_i (data_i),
        .data_o (data_o),
        .out0_o (out0_o),
        .irq0_o (irq0_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // Write one byte; e returns the clock edge number that captures it.
    task automatic wr(input logic [7:0] p, input logic [7:0] d, output int e);
        we_i = 1'b1; port_i = p; data_i = d; e = cyc + 1;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] p, input logic [7:0] exp_b);
        re_i = 1'b1; port_i = p;
        q_rd.push_back(exp_b);
        @(negedge clk);
        re_i = 1'b0;
    endtask

    // Return at the negedge just before edge n, so the next wr/rd lands on edge n.
    task automatic wait_to(input int n);
        while (cyc < n - 1) @(negedge clk);
    endtask

    task automatic exp_lvl(input int c, input logic v);
        lvl_t le;
        le.cyc = c; le.lvl = v;
        q_lvl.push_back(le);
    endtask

    // Monitor: numbers edges and checks outputs 1 time unit after each edge.
    always @(posedge clk) begin
        logic rd_s;
        int   ei;
        lvl_t le;
        cyc  = cyc + 1;
        rd_s = re_i;
        #1;
        if (rd_s) begin
            if (q_rd.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL rd_unexpected: got %0h with no expected byte (edge %0d)", data_o, cyc);
            end else begin
                chk("rd_data", data_o, q_rd.pop_front());
            end
        end
        if (irq0_o) begin
            if (q_irq.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL irq_unexpected: got pulse at edge %0d expected none", cyc);
            end else begin
                ei = q_irq.pop_front();
                chk("irq_edge", cyc, ei);
            end
        end
        if ((q_lvl.size() > 0) && (q_lvl[0].cyc == cyc)) begin
            le = q_lvl.pop_front();
            chk("out0_level", out0_o, le.lvl);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int w;
        int l;
        rst = 1'b1; we_i = 1'b0; re_i = 1'b0; port_i = 8'h00; data_i = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out0", out0_o, 1'b0);
        chk("rst_irq0", irq0_o, 1'b0);
        chk("rst_data", data_o, 8'h00);
        rd(CNT0, 8'h00);
        rd(CNT0, 8'h00);

        // Mode 2, N=5: low one clk every 5, irq at each return high.
        wr(CTRL, 8'h34, e);
        wr(CNT0, 8'h05, e);
        wr(CNT0, 8'h00, w);
        exp_lvl(w + 5, 1'b0);  exp_lvl(w + 6, 1'b1);
        exp_lvl(w + 10, 1'b0); exp_lvl(w + 11, 1'b1);
        exp_lvl(w + 15, 1'b0); exp_lvl(w + 25, 1'b0);
        q_irq.push_back(w + 6);  q_irq.push_back(w + 11);
        q_irq.push_back(w + 16); q_irq.push_back(w + 21);
        // Control write on the reload tick: forced high, no irq.
        exp_lvl(w + 26, 1'b1);
        wait_to(w + 26);
        wr(CTRL, 8'h36, e);

        // Mode 3, N=7: high 4, low 3.
        wr(CNT0, 8'h07, e);
        wr(CNT0, 8'h00, w);
        exp_lvl(w + 4, 1'b1);  exp_lvl(w + 5, 1'b0);
        exp_lvl(w + 7, 1'b0);  exp_lvl(w + 8, 1'b1);
        exp_lvl(w + 11, 1'b1); exp_lvl(w + 12, 1'b0);
        exp_lvl(w + 14, 1'b0); exp_lvl(w + 15, 1'b1);
        q_irq.push_back(w + 8); q_irq.push_back(w + 15); q_irq.push_back(w + 22);
        wait_to(w + 24);
        wr(CTRL, 8'h36, e);

        // Mode 3, N=4 then rewrite 6 mid-low-phase: new value used from the next reload.
        wr(CNT0, 8'h04, e);
        wr(CNT0, 8'h00, w);
        exp_lvl(w + 1, 1'b1);  exp_lvl(w + 3, 1'b0);
        exp_lvl(w + 5, 1'b1);  exp_lvl(w + 6, 1'b1);
        exp_lvl(w + 7, 1'b0);  exp_lvl(w + 8, 1'b0);
        exp_lvl(w + 9, 1'b1);  exp_lvl(w + 11, 1'b1);
        exp_lvl(w + 12, 1'b0); exp_lvl(w + 14, 1'b0);
        exp_lvl(w + 15, 1'b1); exp_lvl(w + 23, 1'b0);
        q_irq.push_back(w + 5);  q_irq.push_back(w + 9);
        q_irq.push_back(w + 15); q_irq.push_back(w + 21);
        wait_to(w + 6);
        wr(CNT0, 8'h06, e);
        wr(CNT0, 8'h00, e);
        wait_to(w + 23);
        wr(CTRL, 8'h30, e);

        // Mode 0, N=3: rises load+3 ticks, single irq, stays high through wrap.
        wr(CNT0, 8'h03, e);
        wr(CNT0, 8'h00, w);
        exp_lvl(w + 3, 1'b0); exp_lvl(w + 4, 1'b1); exp_lvl(w + 10, 1'b1);
        q_irq.push_back(w + 4);
        wait_to(w + 8);
        rd(CNT0, 8'hFD);
        rd(CNT0, 8'hFF);

        // Mode 2, N=0x1234: latch, ignored second latch, reads, then live read.
        wr(CTRL, 8'h34, e);
        wr(CNT0, 8'h34, e);
        wr(CNT0, 8'h12, w);
        wait_to(w + 5);
        wr(CTRL, 8'h00, l);
        exp_lvl(l + 8, 1'b1);
        wait_to(l + 3);
        wr(CTRL, 8'h00, e);
        rd(8'h41, 8'h00);
        rd(CNT0, 8'h31);
        rd(CNT0, 8'h12);
        wait_to(l + 10);
        rd(CNT0, 8'h27);
        rd(CNT0, 8'h12);

        // Asynchronous reset mid-count.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out0", out0_o, 1'b0);
        chk("arst_irq0", irq0_o, 1'b0);
        chk("arst_data", data_o, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_out0", out0_o, 1'b0);
        rd(CNT0, 8'h00);
        @(negedge clk);

        chk("q_rd_empty", q_rd.size(), 0);
        chk("q_irq_empty", q_irq.size(), 0);
        chk("q_lvl_empty", q_lvl.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pit_timer.md
Name: pit_timer

Overview:
Simplified 8253/8254-style programmable interval timer, channel 0 only. It is the stage directly upstream of the 8259A interrupt controller and is the source of the timer interrupt (IRQ0) that the controller reports. The CPU programs it through byte-wide port writes: control port 0x43, counter port 0x40.

Parameters:
PRESCALE, 4, clk cycles per counter tick (>=1; 1 = tick every clk)
CTRL_PORT, 8'h43, control-word port address
CNT0_PORT, 8'h40, counter-0 data port address

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
we_i  in  1  port write strobe, one clk per byte
re_i  in  1  port read strobe, one clk per byte
port_i  in  8  port address
data_i  in  8  write data
data_o  out  8  read data, registered, valid the clk after re_i
out0_o  out  1  counter-0 output level
irq0_o  out  1  one-clk pulse on each rising edge of out0_o, to 8259A IR0

Behaviour:
- Reset (async, rst=1): data_o=0, out0_o=0, irq0_o=0; counter=0, prescaler=0, mode=0, RW=11; byte-flip-flop = LSB; latch empty; channel idle (not counting).
- Tick: prescaler counts 0..PRESCALE-1; tick asserted in the clk it wraps. Counting only occurs on ticks. Prescaler free-runs and is never reset by writes.
- Control write (we_i, port_i=CTRL_PORT):
  - bits[7:6] must be 00, else ignored.
  - RW=bits[5:4]: 00 latch command; 01 LSB only; 10 MSB only; 11 LSB then MSB.
  - mode=bits[3:1]: 000 mode0; x10 mode2; x11 mode3; any other value treated as mode0.
  - bit0 (BCD) ignored; binary only.
  - Non-latch write: sets mode/RW, resets byte flip-flop, channel goes idle, out0_o forced to initial level (mode0: 0; mode2/3: 1) next clk.
  - Latch command (RW=00): copies live counter to latch, unless a latch is already pending, in which case it is ignored.
- Count write (port_i=CNT0_PORT): assembled per RW. For RW=11, count is complete after the MSB write.
  - Count 0 means 65536.
  - Modes 2/3: count 1 is treated as 2.
- Count load, mode0 or idle channel: counter loads on the first tick after count completion; counting begins on the following tick.
- Count load, running mode2/3: new count held pending and loaded at the next period reload.
- Mode0 (interrupt on terminal count):
  - out0_o=0 from count completion.
  - Decrement per tick; counter reaching 0 sets out0_o=1.
  - out0_o stays 1; counter wraps to FFFF and keeps decrementing.
  - A new count restarts the sequence (out0_o=0).
- Mode2 (rate generator):
  - out0_o=1; decrement per tick.
  - In the tick counter reaches 1: out0_o=0 for exactly one tick, then reload and out0_o=1.
  - Period = N ticks.
- Mode3 (square wave):
  - out0_o high for ceil(N/2) ticks, low for floor(N/2) ticks, repeating.
  - Reload at each half-period boundary.
- irq0_o: registered out0_o rising-edge detect, one clk wide. No pulse on reset release or on the forced-high initial level after a control write.
- Read (re_i, port_i=CNT0_PORT):
  - Returns the latch if pending, else the live counter, formatted per RW.
  - RW=11 alternates LSB then MSB using a read flip-flop.
  - Latch cleared after its final byte is read.
  - Reads of other ports return 8'h00.
- Simultaneous events:
  - Write and read in the same clk: write takes effect, read returns the pre-write value.
  - Control write on a tick clk overrides counting.
- Reset mid-count: immediate return to reset state; no irq0_o pulse.

Test Plan:
- Reset: assert rst mid-operation -> all outputs 0 asynchronously; no irq0_o pulse after release.
- Mode2 rate: PRESCALE=1, ctrl 8'h34, count 0x05/0x00 -> out0_o low 1 clk every 5 clks; irq0_o pulses every 5 clks.
- Mode3: ctrl 8'h36, count 7 -> high 4 ticks, low 3 ticks, repeating.
- Mode3 reload: count 4, then rewrite 6 while running -> change takes effect only at the next reload.
- Mode0: ctrl 8'h30, count 3 -> out0_o=0, goes 1 after load+3 ticks; single irq0_o pulse; stays 1 as the counter wraps.
- Latch/read: mode2 count 0x1234, latch command (8'h00) mid-count, two reads -> LSB then MSB of the latched value; a second latch before the reads is ignored; a later read returns the live value.
